// File: rtl/mollusc_pkg.sv
// Shared types for the mollusc memory-side blocks: memory arbiter FSM states
// and the transaction owner encoding.
package mollusc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } arb_state_t;

    localparam logic OWN_FETCH = 1'b0;
    localparam logic OWN_DATA  = 1'b1;

endpackage

// File: rtl/arb_pick.sv
// Two-input grant picker for the memory port; holds all arbitration policy.
// Build with MEM_ARB_RR_EN for round-robin on conflict, otherwise data beats fetch.
module arb_pick
    import mollusc_pkg::*;
(
    input  logic if_req,
    input  logic d_req,
    input  logic win_open,
    input  logic last_served,
    output logic if_gnt,
    output logic d_gnt
);

    logic data_wins;

`ifdef MEM_ARB_RR_EN
    // On a conflict, the requester that did not go last gets the port.
    assign data_wins = ~if_req | (last_served == OWN_FETCH);
`else
    logic unused_last_served;
    assign unused_last_served = last_served;
    assign data_wins          = 1'b1;
`endif

    assign d_gnt  = win_open & d_req & data_wins;
    assign if_gnt = win_open & if_req & ~d_gnt;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory bus between fetch and data requesters with a single
// transaction in flight. MEM_ARB_RR_EN selects round-robin conflict resolution.
module mem_port_arbiter
    import mollusc_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    output logic          stall_fetch,
    input  logic          d_req,
    input  logic          d_write,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic          stall_exec,
    output logic          mem_req,
    output logic          mem_write,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ready,
    input  logic          mem_rvalid,
    input  logic [DW-1:0] mem_rdata
);

    arb_state_t state;
    logic       owner;
    logic       last_served;
    logic       win_open;

    // The response cycle doubles as a grant window so back-to-back traffic takes 2 cycles.
    assign win_open = (state == IDLE) || (state == WAIT && mem_rvalid);

    arb_pick u_pick (
        .if_req      (if_req),
        .d_req       (d_req),
        .win_open    (win_open),
        .last_served (last_served),
        .if_gnt      (if_gnt),
        .d_gnt       (d_gnt)
    );

    assign stall_fetch = if_req & ~if_gnt;
    assign stall_exec  = d_req & ~d_gnt;

`ifdef MEM_ARB_RR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_served <= OWN_FETCH;
        end else if (if_gnt | d_gnt) begin
            last_served <= d_gnt ? OWN_DATA : OWN_FETCH;
        end
    end
`else
    assign last_served = OWN_FETCH;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            owner     <= OWN_FETCH;
            mem_req   <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rvalid <= 1'b0;
            d_rvalid  <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
        end else begin
            if_rvalid <= 1'b0;
            d_rvalid  <= 1'b0;
            case (state)
                IDLE: begin
                end
                REQ: begin
                    if (mem_ready) begin
                        state   <= WAIT;
                        mem_req <= 1'b0;
                    end
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        if (owner == OWN_DATA) begin
                            d_rvalid <= 1'b1;
                            d_rdata  <= mem_rdata;
                        end else begin
                            if_rvalid <= 1'b1;
                            if_rdata  <= mem_rdata;
                        end
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            // A grant can only fire inside the window, so it overrides the return to IDLE.
            if (if_gnt | d_gnt) begin
                state     <= REQ;
                mem_req   <= 1'b1;
                owner     <= d_gnt ? OWN_DATA : OWN_FETCH;
                mem_write <= d_gnt & d_write;
                mem_addr  <= d_gnt ? d_addr : if_addr;
                mem_wdata <= d_gnt ? d_wdata : '0;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: grant and transaction tables,
// corner-case sequences, and randomized traffic against a transaction-level model.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          if_req, d_req, d_write;
    logic [AW-1:0] if_addr, d_addr;
    logic [DW-1:0] d_wdata;
    logic          if_gnt, if_rvalid, stall_fetch;
    logic [DW-1:0] if_rdata;
    logic          d_gnt, d_rvalid, stall_exec;
    logic [DW-1:0] d_rdata;
    logic          mem_req, mem_write;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ready, mem_rvalid;
    logic [DW-1:0] mem_rdata;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
        .if_rdata(if_rdata), .stall_fetch(stall_fetch),
        .d_req(d_req), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .stall_exec(stall_exec),
        .mem_req(mem_req), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;

    typedef struct packed {
        logic ifr, dr, eig, edg;
    } gvec_t;

    typedef struct {
        logic        d;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          rw;
        int          vw;
        int          lat;
    } tvec_t;

    gvec_t gtab[4];
    tvec_t ttab[4];

    task automatic chk1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chkw(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic idle_inputs();
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_write = 1'b0; d_addr = '0; d_wdata = '0;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic run_txn(input tvec_t t);
        int  c0;
        bit  got;
        if_req = !t.d; d_req = t.d;
        if_addr = t.addr; d_addr = t.addr; d_write = t.wr; d_wdata = t.wdata;
        #1;
        chk1("txn_c0_gnt", t.d ? d_gnt : if_gnt, 1'b1);
        chk1("txn_c0_other_gnt", t.d ? if_gnt : d_gnt, 1'b0);
        c0 = cyc;
        step();
        if_req = 1'b0; d_req = 1'b0;
        #1;
        chk1("txn_c1_mem_req", mem_req, 1'b1);
        chkw("txn_c1_mem_addr", mem_addr, t.addr);
        chk1("txn_c1_mem_write", mem_write, t.wr);
        if (t.wr) chkw("txn_c1_mem_wdata", mem_wdata, t.wdata);
        for (int i = 0; i < t.rw; i++) begin
            mem_ready = 1'b0;
            step();
            #1;
            chk1("txn_hold_mem_req", mem_req, 1'b1);
            chkw("txn_hold_mem_addr", mem_addr, t.addr);
            if (t.wr) chkw("txn_hold_mem_wdata", mem_wdata, t.wdata);
        end
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        for (int i = 0; i < t.vw; i++) step();
        mem_rvalid = 1'b1; mem_rdata = t.rdata;
        step();
        mem_rvalid = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 8; k++) begin
            #1;
            if ((t.d ? d_rvalid : if_rvalid) === 1'b1) begin
                got = 1'b1;
                break;
            end
            step();
        end
        chk1("txn_rsp_seen", got, 1'b1);
        if (got) begin
            chkw("txn_latency", cyc - c0, t.lat);
            chkw("txn_rdata", t.d ? d_rdata : if_rdata, t.rdata);
            chk1("txn_other_rvalid", t.d ? if_rvalid : d_rvalid, 1'b0);
            step();
            #1;
            chk1("txn_rvalid_pulse", t.d ? d_rvalid : if_rvalid, 1'b0);
        end
        step();
    endtask

    // Transaction-level reference model state for the randomized phase.
    bit          m_busy, m_hs, m_rsp, m_rsp_own, m_last, cur_own, cur_wr;
    logic [31:0] m_rsp_data, cur_addr, cur_wd;
    bit          bus_out, if_done, d_done, win, data_wins, e_if, e_d, rv_next;
    int          bus_cnt, ng;

    initial begin
        gtab[0] = '{1'b0, 1'b0, 1'b0, 1'b0};
        gtab[1] = '{1'b1, 1'b0, 1'b1, 1'b0};
        gtab[2] = '{1'b0, 1'b1, 1'b0, 1'b1};
        gtab[3] = '{1'b1, 1'b1, 1'b0, 1'b1};
        ttab[0] = '{1'b0, 1'b0, 32'h100, 32'h0,  32'hDEADBEEF, 0, 0, 3};
        ttab[1] = '{1'b1, 1'b0, 32'h300, 32'h0,  32'h12345678, 1, 2, 6};
        ttab[2] = '{1'b1, 1'b1, 32'h200, 32'h55, 32'h00000000, 4, 0, 7};
        ttab[3] = '{1'b0, 1'b0, 32'h104, 32'h0,  32'hCAFEF00D, 0, 3, 6};

        idle_inputs();
        #2 rst_n = 1'b0;
        #1;
        chk1("rst_mem_req", mem_req, 1'b0);
        chk1("rst_mem_write", mem_write, 1'b0);
        chkw("rst_mem_addr", mem_addr, 32'h0);
        chkw("rst_mem_wdata", mem_wdata, 32'h0);
        chk1("rst_if_rvalid", if_rvalid, 1'b0);
        chk1("rst_d_rvalid", d_rvalid, 1'b0);
        chkw("rst_if_rdata", if_rdata, 32'h0);
        chkw("rst_d_rdata", d_rdata, 32'h0);
        step();
        step();
        rst_n = 1'b1;
        step();

        // Grant table from IDLE; requests are withdrawn before the clock edge.
        for (int i = 0; i < 4; i++) begin
            if_req = gtab[i].ifr; d_req = gtab[i].dr;
            #1;
            chk1("tab_if_gnt", if_gnt, gtab[i].eig);
            chk1("tab_d_gnt", d_gnt, gtab[i].edg);
            chk1("tab_stall_fetch", stall_fetch, gtab[i].ifr & ~gtab[i].eig);
            chk1("tab_stall_exec", stall_exec, gtab[i].dr & ~gtab[i].edg);
            if_req = 1'b0; d_req = 1'b0;
            step();
        end

        for (int i = 0; i < 4; i++) run_txn(ttab[i]);

        // Conflict: store wins, fetch is granted in the store's response cycle.
        do_reset();
        if_req = 1'b1; if_addr = 32'h100;
        d_req = 1'b1; d_write = 1'b1; d_addr = 32'h200; d_wdata = 32'h55;
        #1;
        chk1("conf_d_gnt", d_gnt, 1'b1);
        chk1("conf_if_gnt", if_gnt, 1'b0);
        chk1("conf_stall_fetch", stall_fetch, 1'b1);
        chk1("conf_stall_exec", stall_exec, 1'b0);
        step();
        d_req = 1'b0; mem_ready = 1'b1;
        #1;
        chkw("conf_mem_addr", mem_addr, 32'h200);
        chk1("conf_mem_write", mem_write, 1'b1);
        chkw("conf_mem_wdata", mem_wdata, 32'h55);
        chk1("conf_busy_stall_fetch", stall_fetch, 1'b1);
        chk1("conf_busy_if_gnt", if_gnt, 1'b0);
        step();
        mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0;
        #1;
        chk1("conf_rsp_if_gnt", if_gnt, 1'b1);
        chk1("conf_rsp_stall_fetch", stall_fetch, 1'b0);
        step();
        mem_rvalid = 1'b0; if_req = 1'b0;
        #1;
        chk1("conf_store_ack", d_rvalid, 1'b1);
        chk1("conf_store_no_if_rvalid", if_rvalid, 1'b0);
        chk1("conf_fetch_mem_req", mem_req, 1'b1);
        chkw("conf_fetch_mem_addr", mem_addr, 32'h100);
        chk1("conf_fetch_mem_write", mem_write, 1'b0);
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000F00D;
        step();
        mem_rvalid = 1'b0;
        #1;
        chk1("conf_fetch_rvalid", if_rvalid, 1'b1);
        chkw("conf_fetch_rdata", if_rdata, 32'h0000F00D);

        // Both requesters held for six zero-wait transactions.
        do_reset();
        if_req = 1'b1; d_req = 1'b1; if_addr = 32'h400; d_addr = 32'h800; d_write = 1'b0;
        ng = 0; rv_next = 1'b0;
        for (int k = 0; k < 40 && ng < 6; k++) begin
            mem_ready = mem_req;
            mem_rvalid = rv_next;
            rv_next = mem_req;
            #1;
            chk1("seq_no_dual_gnt", if_gnt & d_gnt, 1'b0);
            if (if_gnt | d_gnt) begin
`ifdef MEM_ARB_RR_EN
                chk1("seq_rr_owner", d_gnt, (ng % 2) == 0);
`else
                chk1("seq_fixed_owner", d_gnt, 1'b1);
`endif
                ng++;
            end
            step();
        end
        chkw("seq_grant_count", ng, 6);

        // Async reset while the request is on the bus drops mem_req before any edge.
        do_reset();
        if_req = 1'b1; if_addr = 32'h500;
        #1;
        chk1("rstreq_gnt", if_gnt, 1'b1);
        step();
        if_req = 1'b0;
        #1;
        chk1("rstreq_mem_req_on", mem_req, 1'b1);
        rst_n = 1'b0;
        #1;
        chk1("rstreq_mem_req_drop", mem_req, 1'b0);
        step();
        rst_n = 1'b1;
        step();

        // Async reset during WAIT, late response must be discarded.
        if_req = 1'b1; if_addr = 32'h600;
        #1;
        chk1("rstwait_gnt", if_gnt, 1'b1);
        step();
        if_req = 1'b0; mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        chk1("rstwait_mem_req", mem_req, 1'b0);
        step();
        rst_n = 1'b1;
        step();
        mem_rvalid = 1'b1; mem_rdata = 32'h00000BAD;
        step();
        mem_rvalid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk1("rstwait_no_if_rvalid", if_rvalid, 1'b0);
            chk1("rstwait_no_d_rvalid", d_rvalid, 1'b0);
            chk1("rstwait_no_mem_req", mem_req, 1'b0);
            step();
        end
        run_txn(ttab[0]);

        // Stray response while IDLE.
        mem_rvalid = 1'b1; mem_rdata = 32'h0BADF00D;
        step();
        mem_rvalid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk1("idle_rv_if_rvalid", if_rvalid, 1'b0);
            chk1("idle_rv_d_rvalid", d_rvalid, 1'b0);
            chk1("idle_rv_mem_req", mem_req, 1'b0);
            step();
        end

        // Randomized traffic with a random-latency bus and stray responses.
        do_reset();
        m_busy = 0; m_hs = 0; m_rsp = 0; m_rsp_own = 0; m_last = 0;
        cur_own = 0; cur_wr = 0; cur_addr = '0; cur_wd = '0; m_rsp_data = '0;
        bus_out = 0; bus_cnt = 0; if_done = 0; d_done = 0;
        for (int c = 0; c < 3000; c++) begin
            if (!if_req || if_done) begin
                if_req = ($urandom_range(0, 1) == 1);
                if_addr = $urandom;
            end
            if (!d_req || d_done) begin
                d_req = ($urandom_range(0, 2) == 0);
                d_addr = $urandom;
                d_write = 1'($urandom_range(0, 1));
                d_wdata = $urandom;
            end
            mem_ready = mem_req && ($urandom_range(0, 2) != 0);
            if (bus_out && bus_cnt == 0) begin
                mem_rvalid = 1'b1; mem_rdata = $urandom;
            end else if (!bus_out && $urandom_range(0, 7) == 0) begin
                mem_rvalid = 1'b1; mem_rdata = $urandom;
            end else begin
                mem_rvalid = 1'b0;
            end
            #1;
            win = !m_busy || (m_hs && mem_rvalid);
`ifdef MEM_ARB_RR_EN
            data_wins = !if_req || !m_last;
`else
            data_wins = 1'b1;
`endif
            e_d  = win && d_req && data_wins;
            e_if = win && if_req && !e_d;
            chk1("rnd_if_gnt", if_gnt, e_if);
            chk1("rnd_d_gnt", d_gnt, e_d);
            chk1("rnd_stall_fetch", stall_fetch, if_req && !e_if);
            chk1("rnd_stall_exec", stall_exec, d_req && !e_d);
            chk1("rnd_mem_req", mem_req, m_busy && !m_hs);
            if (m_busy && !m_hs) begin
                chkw("rnd_mem_addr", mem_addr, cur_addr);
                chk1("rnd_mem_write", mem_write, cur_wr);
                if (cur_wr) chkw("rnd_mem_wdata", mem_wdata, cur_wd);
            end
            chk1("rnd_if_rvalid", if_rvalid, m_rsp && !m_rsp_own);
            chk1("rnd_d_rvalid", d_rvalid, m_rsp && m_rsp_own);
            if (m_rsp) chkw("rnd_rdata", m_rsp_own ? d_rdata : if_rdata, m_rsp_data);

            m_rsp = 1'b0;
            if (m_busy && m_hs && mem_rvalid) begin
                m_rsp = 1'b1; m_rsp_own = cur_own; m_rsp_data = mem_rdata; m_busy = 1'b0;
            end else if (m_busy && !m_hs && mem_ready) begin
                m_hs = 1'b1;
            end
            if (e_if || e_d) begin
                m_busy = 1'b1; m_hs = 1'b0; cur_own = e_d;
                cur_addr = e_d ? d_addr : if_addr;
                cur_wr = e_d && d_write;
                cur_wd = d_wdata;
                m_last = e_d;
            end
            if_done = if_gnt;
            d_done = d_gnt;
            if (bus_out && mem_rvalid) begin
                bus_out = 1'b0;
            end else if (bus_out) begin
                bus_cnt--;
            end else if (mem_req && mem_ready) begin
                bus_out = 1'b1;
                bus_cnt = $urandom_range(0, 2);
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
